typed_sequence_builder: RTL and testbench
=========================================

Name: typed_sequence_builder

Overview:
- Initiator end of the sequence-plot handshake. Collects keystroke character codes from the keyboard decoder into a fixed line buffer of MAX_CHAR slots, with append, backspace and clear.
- Drives sequence_/num_char/x_start/y_start/plot_sequence into the sequence drawing block, and requests a full-line redraw whenever the buffer changes.
- Sits between the PS/2 key decoder and the VGA sequence plotter on the player-input line.

Parameters:
- MAX_CHAR, 11: number of character slots. sequence_ width is 8*MAX_CHAR = 88.
- BLANK_CODE, 8'd32: character code written into empty slots, so they erase on redraw.
- X_START, 9'd16: x pixel of slot 0, driven on x_start.
- Y_START, 9'd200: y pixel of the line, driven on y_start.
- ACK_TIMEOUT, 4: cycles to wait for ready_to_plot_sequence to drop after a plot request.

Ports:
- clk  in  1  system clock; all state on rising edge.
- resetn  in  1  reset.
- key_valid  in  1  one-cycle pulse; key_code is a printable char to append.
- key_code  in  8  character code (font ROM address).
- key_backspace  in  1  one-cycle pulse; delete last char.
- key_clear  in  1  one-cycle pulse; empty the buffer.
- ready_to_plot_sequence  in  1  plotter idle/accepting.
- plot_sequence  out  1  one-cycle plot request.
- sequence_  out  88  snapshot; slot 0 in [87:80], slot i in [87-8i -: 8].
- num_char  out  8  constant MAX_CHAR-1 = 10 (plotter draws num_char+1 chars).
- x_start  out  9  constant X_START.
- y_start  out  9  constant Y_START.
- char_count  out  4  chars currently in buffer, 0..MAX_CHAR.
- buffer_full  out  1  char_count == MAX_CHAR.

Interface decision: one clock (clk); reset resetn is asynchronous and active-low.

Behaviour:
Reset (async, resetn=0):
- Buffer and sequence_ all BLANK_CODE; char_count=0; buffer_full=0; plot_sequence=0.
- State S_IDLE; dirty=1, so a blank line is drawn after reset.
- num_char, x_start, y_start take their constants.
- Reset asserted mid-operation aborts any request immediately; no partial outputs persist.

Key events (sampled every cycle, in all FSM states):
- Priority: key_clear > key_backspace > key_valid. Only the highest-priority event present that cycle acts.
- clear: all slots BLANK, count=0, dirty=1 (even if already empty).
- backspace: if count>0, slot[count-1]=BLANK, count-1, dirty=1. If count==0, no change and dirty is untouched.
- valid: if count<MAX_CHAR, slot[count]=key_code, count+1, dirty=1. If full, the key is dropped and dirty is untouched.
- char_count and buffer_full are registered and update the cycle after the event edge.

Plot FSM:
- S_IDLE: if dirty && ready_to_plot_sequence, go to S_ISSUE. At that edge, load sequence_ from the buffer, set plot_sequence=1 and clear dirty. A key event on the same edge sets dirty, and set wins over clear.
- S_ISSUE: plot_sequence=1 for exactly one cycle, then S_WAIT_ACK with the timeout counter at 0.
- S_WAIT_ACK: if ready==0, go to S_WAIT_DONE. Otherwise count; when the counter reaches ACK_TIMEOUT, return to S_IDLE.
- S_WAIT_DONE: when ready==1, go to S_IDLE.
- sequence_ changes only on the S_IDLE->S_ISSUE edge, so it is stable while the plotter loads and shifts it.
- Keys during S_ISSUE/S_WAIT_* update the buffer and dirty only. The redraw follows after return to S_IDLE.
- Minimum request spacing is 3 cycles.
- Latency: an event at edge N with the FSM idle and ready=1 gives plot_sequence high in cycle N+2 (dirty registered at N, S_ISSUE entered at N+1).

Test Plan:
- Release resetn with ready=1 -> one plot_sequence pulse; sequence_ = 11 x 8'h20; num_char=10; x_start=16; y_start=200; char_count=0.
- Key 8'h41 then 8'h42, one plot at a time with the plotter model acking -> final sequence_[87:72]=16'h4142, remainder 8'h20; char_count=2.
- 12 key_valid pulses of 8'h61 -> char_count=11, buffer_full=1, 12th dropped; the last snapshot has all slots 8'h61. Then a backspace -> slot 10 = 8'h20, char_count=10, buffer_full=0.
- key_clear and key_valid(8'h5A) in the same cycle with count=3 -> buffer all blank, char_count=0; 8'h5A ignored.
- Hold ready=0 after a request, type 'X' -> sequence_ unchanged, no second pulse until ready returns 1. Then exactly one new pulse with 'X' present.
- Hold ready=1 constantly after a request -> FSM returns to S_IDLE after 4 cycles; next pulse no earlier than 3 cycles after the previous one.
- Backspace at count=0 -> no plot pulse, char_count stays 0.

Source files
------------

// File: rtl/typed_sequence_builder.sv
// Keystroke line buffer that feeds the VGA sequence plotter: append, backspace
// and clear edit the buffer, and any change requests a full-line redraw.
module typed_sequence_builder #(
  parameter int         MAX_CHAR    = 11,
  parameter logic [7:0] BLANK_CODE  = 8'd32,
  parameter logic [8:0] X_START     = 9'd16,
  parameter logic [8:0] Y_START     = 9'd200,
  parameter int         ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  input  logic                  key_backspace,
  input  logic                  key_clear,
  input  logic                  ready_to_plot_sequence,
  output logic                  plot_sequence,
  output logic [8*MAX_CHAR-1:0] sequence_,
  output logic [7:0]            num_char,
  output logic [8:0]            x_start,
  output logic [8:0]            y_start,
  output logic [3:0]            char_count,
  output logic                  buffer_full
);

  localparam logic [3:0] MAX_CNT      = 4'(MAX_CHAR);
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [7:0]            slots      [MAX_CHAR];
  logic [7:0]            slots_next [MAX_CHAR];
  logic [3:0]            count_next;
  logic                  key_dirty;
  logic                  dirty;
  logic                  take_req;
  logic [1:0]            state;
  logic [3:0]            timer;
  logic [8*MAX_CHAR-1:0] packed_slots;

  assign num_char = 8'(MAX_CHAR - 1);
  assign x_start  = X_START;
  assign y_start  = Y_START;

  // Only the highest-priority key event acts; rejected edits leave dirty alone.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    slots_next = slots;
    count_next = char_count;
    key_dirty  = 1'b0;
    if (key_clear) begin
      for (int i = 0; i < MAX_CHAR; i++) slots_next[i] = BLANK_CODE;
      count_next = 4'd0;
      key_dirty  = 1'b1;
    end else if (key_backspace) begin
      if (char_count != 4'd0) begin
        slots_next[char_count - 4'd1] = BLANK_CODE;
        count_next = char_count - 4'd1;
        key_dirty  = 1'b1;
      end
    end else if (key_valid) begin
      if (char_count < MAX_CNT) begin
        slots_next[char_count] = key_code;
        count_next = char_count + 4'd1;
        key_dirty  = 1'b1;
      end
    end
  end

  always_comb begin
    packed_slots = '0;
    for (int i = 0; i < MAX_CHAR; i++)
      packed_slots[8*(MAX_CHAR-1-i) +: 8] = slots[i];
  end

  // NOTE: the slot array is small and must read as blanks after reset, so it is
  // reset like ordinary flops rather than treated as an unreset memory.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_CHAR; i++) slots[i] <= BLANK_CODE;
      char_count  <= 4'd0;
      buffer_full <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      slots       <= slots_next;
      char_count  <= count_next;
      buffer_full <= (count_next == MAX_CNT);
    end
  end

  assign take_req = (state == S_IDLE) && dirty && ready_to_plot_sequence;

  // A same-edge key event re-sets dirty even as a request consumes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dirty         <= 1'b1;
      state         <= S_IDLE;
      timer         <= 4'd0;
      plot_sequence <= 1'b0;
      sequence_     <= {MAX_CHAR{BLANK_CODE}};
    end else begin
      dirty <= key_dirty | (dirty & ~take_req);
      case (state)
        S_IDLE: begin
          if (take_req) begin
            state         <= S_ISSUE;
            plot_sequence <= 1'b1;
            sequence_     <= packed_slots;
          end
        end
        S_ISSUE: begin
          state         <= S_WAIT_ACK;
          plot_sequence <= 1'b0;
          timer         <= 4'd0;
        end
        S_WAIT_ACK: begin
          if (!ready_to_plot_sequence) begin
            state <= S_WAIT_DONE;
          end else if (timer == TIMEOUT_LAST) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (ready_to_plot_sequence) state <= S_IDLE;
        end
        default: begin
          state         <= S_IDLE;
          plot_sequence <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_typed_sequence_builder.sv
// Directed bench for typed_sequence_builder with a simple acking plotter model.
module tb_typed_sequence_builder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        key_valid, key_backspace, key_clear;
  logic [7:0]  key_code;
  logic        ready_to_plot_sequence;
  logic        plot_sequence;
  logic [87:0] sequence_;
  logic [7:0]  num_char;
  logic [8:0]  x_start, y_start;
  logic [3:0]  char_count;
  logic        buffer_full;

  logic        auto_ack;
  logic        ready_man;
  logic [1:0]  busy_cnt;
  int          cycle;
  int          pulse_count;
  int          last_pulse_cycle;
  int          prev_pulse_cycle;
  int          passed;
  int          total;

  localparam logic [87:0] BLANK_LINE = {11{8'h20}};

  always #5 clk = ~clk;

  typed_sequence_builder dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .key_valid              (key_valid),
    .key_code               (key_code),
    .key_backspace          (key_backspace),
    .key_clear              (key_clear),
    .ready_to_plot_sequence (ready_to_plot_sequence),
    .plot_sequence          (plot_sequence),
    .sequence_              (sequence_),
    .num_char               (num_char),
    .x_start                (x_start),
    .y_start                (y_start),
    .char_count             (char_count),
    .buffer_full            (buffer_full)
  );

  // Plotter model: when acking, it goes busy for three cycles after each request.
  assign ready_to_plot_sequence = auto_ack ? (busy_cnt == 2'd0) : ready_man;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (auto_ack && plot_sequence) busy_cnt <= 2'd3;
    else if (busy_cnt != 2'd0)     busy_cnt <= busy_cnt - 2'd1;
  end

  always @(negedge clk) begin
    if (plot_sequence) begin
      pulse_count      <= pulse_count + 1;
      prev_pulse_cycle <= last_pulse_cycle;
      last_pulse_cycle <= cycle;
    end
  end

  task automatic check(input string tag, input logic [87:0] observed,
                       input logic [87:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic key(input logic v, input logic b, input logic c, input logic [7:0] code);
    key_valid = v; key_backspace = b; key_clear = c; key_code = code;
    tick();
    key_valid = 1'b0; key_backspace = 1'b0; key_clear = 1'b0; key_code = 8'h00;
  endtask

  task automatic wait_pulse(input int budget, output bit got);
    int start;
    start = pulse_count;
    got   = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (pulse_count != start) got = 1'b1;
    end
  endtask

  initial begin
    bit got;
    int snap_count;
    logic [87:0] snap;

    cycle = 0; pulse_count = 0; last_pulse_cycle = 0; prev_pulse_cycle = 0;
    passed = 0; total = 0; busy_cnt = 2'd0;
    auto_ack = 1'b1; ready_man = 1'b1;
    key_valid = 1'b0; key_backspace = 1'b0; key_clear = 1'b0; key_code = 8'h00;
    resetn = 1'b0;
    tick(2);

    check("rst_plot",   88'(plot_sequence), 88'd0);
    check("rst_seq",    sequence_, BLANK_LINE);
    check("rst_count",  88'(char_count), 88'd0);
    check("rst_full",   88'(buffer_full), 88'd0);
    check("num_char",   88'(num_char), 88'd10);
    check("x_start",    88'(x_start), 88'd16);
    check("y_start",    88'(y_start), 88'd200);

    resetn = 1'b1;
    wait_pulse(5, got);
    check("post_reset_pulse", 88'(got), 88'd1);
    check("post_reset_seq", sequence_, BLANK_LINE);
    tick(8);
    check("post_reset_single", 88'(pulse_count), 88'd1);

    // Two keys, each redrawn with the plotter acking.
    key(1, 0, 0, 8'h41);
    wait_pulse(6, got);
    check("pulse_A", 88'(got), 88'd1);
    tick(8);
    key(1, 0, 0, 8'h42);
    wait_pulse(6, got);
    check("pulse_B", 88'(got), 88'd1);
    check("seq_AB", sequence_, {8'h41, 8'h42, {9{8'h20}}});
    check("count_AB", 88'(char_count), 88'd2);
    tick(8);

    // Fill to capacity; the 12th key is dropped.
    key(0, 0, 1, 8'h00);
    tick(10);
    for (int i = 0; i < 12; i++) key(1, 0, 0, 8'h61);
    check("full_count", 88'(char_count), 88'd11);
    check("full_flag",  88'(buffer_full), 88'd1);
    tick(15);
    check("full_seq", sequence_, {11{8'h61}});
    key(0, 1, 0, 8'h00);
    check("bksp_count", 88'(char_count), 88'd10);
    check("bksp_full",  88'(buffer_full), 88'd0);
    tick(12);
    check("bksp_seq", sequence_, {{10{8'h61}}, 8'h20});

    // Clear beats a same-cycle append.
    key(0, 0, 1, 8'h00);
    key(1, 0, 0, 8'h31);
    key(1, 0, 0, 8'h32);
    key(1, 0, 0, 8'h33);
    check("count3", 88'(char_count), 88'd3);
    tick(12);
    key(1, 0, 1, 8'h5A);
    check("clr_prio_count", 88'(char_count), 88'd0);
    check("clr_prio_full",  88'(buffer_full), 88'd0);
    tick(12);
    check("clr_prio_seq", sequence_, BLANK_LINE);

    // Plotter held busy: no second request until ready returns.
    auto_ack = 1'b0; ready_man = 1'b1;
    key(1, 0, 0, 8'h51);
    wait_pulse(6, got);
    check("pulse_Q", 88'(got), 88'd1);
    ready_man = 1'b0;
    snap = sequence_;
    check("seq_Q", snap, {8'h51, {10{8'h20}}});
    snap_count = pulse_count;
    key(1, 0, 0, 8'h58);
    tick(10);
    check("busy_no_pulse", 88'(pulse_count), 88'(snap_count));
    check("busy_seq_stable", sequence_, snap);
    ready_man = 1'b1;
    wait_pulse(6, got);
    check("pulse_X", 88'(got), 88'd1);
    check("seq_QX", sequence_, {8'h51, 8'h58, {9{8'h20}}});
    tick(10);
    check("single_X", 88'(pulse_count), 88'(snap_count + 1));

    // Ready held high: timeout return, then a spaced follow-up request.
    key(1, 0, 0, 8'h59);
    wait_pulse(6, got);
    check("pulse_Y", 88'(got), 88'd1);
    key(1, 0, 0, 8'h5A);
    wait_pulse(12, got);
    check("pulse_Z", 88'(got), 88'd1);
    check("spacing", 88'(last_pulse_cycle - prev_pulse_cycle >= 3), 88'd1);
    check("seq_QXYZ", sequence_, {32'h51585_95A, {7{8'h20}}});
    check("count4", 88'(char_count), 88'd4);
    tick(10);

    // Backspace on an empty buffer changes nothing and requests nothing.
    key(0, 0, 1, 8'h00);
    tick(12);
    snap_count = pulse_count;
    key(0, 1, 0, 8'h00);
    tick(10);
    check("empty_bksp_pulse", 88'(pulse_count), 88'(snap_count));
    check("empty_bksp_count", 88'(char_count), 88'd0);

    // Reset mid-operation clears everything immediately.
    key(1, 0, 0, 8'h41);
    #1 resetn = 1'b0;
    #1;
    check("midrst_count", 88'(char_count), 88'd0);
    check("midrst_plot",  88'(plot_sequence), 88'd0);
    check("midrst_seq",   sequence_, BLANK_LINE);
    tick(2);
    resetn = 1'b1;
    tick(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
